// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: register map, status bit positions
// and the frame state encoding used by both the transmitter and receiver.
package uart_pkg;

  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_STAT = 2'd1;
  localparam logic [1:0] UART_DIVL = 2'd2;
  localparam logic [1:0] UART_DIVH = 2'd3;

  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_TX_READY  = 1;
  localparam int ST_TX_IDLE   = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_INT_EN_LO = 5;
  localparam int ST_INT_EN_HI = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO. A pop on a full FIFO frees the slot for a push in
// the same cycle; a push into a full FIFO without a pop is dropped.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART with programmable bit divisor, one-byte TX holding register,
// RX FIFO and a level interrupt, accessed through the 8-bit register bus.
module uart_core
  import uart_pkg::*;
#(
  parameter int          RX_DEPTH  = 4,
  parameter logic [15:0] RESET_DIV = 16'd433
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_data_in,
  input  logic       reg_write,
  input  logic       reg_read,
  output logic [7:0] reg_data_out,
  output logic       interrupt
);

  localparam int CNT_W = $clog2(RX_DEPTH) + 1;

  logic [15:0] r_div;
  logic [1:0]  r_int_en;
  logic        r_overrun;
  logic        r_frame_err;
  logic        r_hold_valid;
  logic [7:0]  r_hold_data;

  logic w_wr_data, w_wr_stat, w_wr_divl, w_wr_divh, w_rd_data;

  uart_state_e r_tx_state, w_tx_state_nx;
  logic [15:0] r_tx_cnt, w_tx_cnt_nx;
  logic [7:0]  r_tx_shift, w_tx_shift_nx;
  logic [2:0]  r_tx_bit, w_tx_bit_nx;
  logic        r_tx_out, w_tx_out_nx;
  logic        w_tx_load;
  logic        w_tx_tick;

  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  uart_state_e r_rx_state, w_rx_state_nx;
  logic [15:0] r_rx_cnt, w_rx_cnt_nx;
  logic [7:0]  r_rx_shift, w_rx_shift_nx;
  logic [2:0]  r_rx_bit, w_rx_bit_nx;
  logic        r_rx_wait, w_rx_wait_nx;
  logic        w_rx_push, w_rx_ferr;
  logic        w_rx_tick;
  logic [15:0] w_half_load;

  logic [7:0]       w_fifo_dout;
  logic             w_fifo_full, w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_overflow;
  logic             w_rx_avail, w_tx_ready, w_tx_idle;
  logic [7:0]       w_status;

  assign w_wr_data = reg_write && (reg_addr == UART_DATA);
  assign w_wr_stat = reg_write && (reg_addr == UART_STAT);
  assign w_wr_divl = reg_write && (reg_addr == UART_DIVL);
  assign w_wr_divh = reg_write && (reg_addr == UART_DIVH);
  assign w_rd_data = reg_read  && (reg_addr == UART_DATA);

  // ---------------- transmitter ----------------
  assign w_tx_tick = (r_tx_cnt == 16'd0);

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_shift_nx = r_tx_shift;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_out_nx   = r_tx_out;
    w_tx_load     = 1'b0;
    if (r_tx_state != S_IDLE) w_tx_cnt_nx = w_tx_tick ? r_div : r_tx_cnt - 16'd1;
    case (r_tx_state)
      S_IDLE: begin
        if (r_hold_valid) begin
          w_tx_load     = 1'b1;
          w_tx_shift_nx = r_hold_data;
          w_tx_out_nx   = 1'b0;
          w_tx_cnt_nx   = r_div;
          w_tx_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_tx_tick) begin
          w_tx_out_nx   = r_tx_shift[0];
          w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_nx   = 3'd0;
          w_tx_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tx_tick) begin
          if (r_tx_bit == 3'd7) begin
            w_tx_out_nx   = 1'b1;
            w_tx_state_nx = S_STOP;
          end else begin
            w_tx_out_nx   = r_tx_shift[0];
            w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
            w_tx_bit_nx   = r_tx_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        // A waiting byte starts immediately so consecutive frames have no gap.
        if (w_tx_tick) begin
          if (r_hold_valid) begin
            w_tx_load     = 1'b1;
            w_tx_shift_nx = r_hold_data;
            w_tx_out_nx   = 1'b0;
            w_tx_state_nx = S_START;
          end else begin
            w_tx_state_nx = S_IDLE;
          end
        end
      end
      default: w_tx_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state   <= S_IDLE;
      r_tx_cnt     <= 16'd0;
      r_tx_bit     <= 3'd0;
      r_tx_out     <= 1'b1;
      r_hold_valid <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_out   <= w_tx_out_nx;
      if (w_tx_load)                      r_hold_valid <= 1'b0;
      else if (w_wr_data && !r_hold_valid) r_hold_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    r_tx_shift <= w_tx_shift_nx;
    if (w_wr_data && !r_hold_valid) r_hold_data <= reg_data_in;
  end

  assign uart_tx = r_tx_out;

  // ---------------- receiver ----------------
  // Reload value giving a start-bit wait of floor((DIV+1)/2) clocks (min 1).
  assign w_half_load = (r_div[0] || (r_div == 16'd0)) ? (r_div >> 1) : (r_div >> 1) - 16'd1;
  assign w_rx_tick   = (r_rx_cnt == 16'd0);

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt;
    w_rx_shift_nx = r_rx_shift;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_wait_nx  = r_rx_wait;
    w_rx_push     = 1'b0;
    w_rx_ferr     = 1'b0;
    if (r_rx_state != S_IDLE && !r_rx_wait) w_rx_cnt_nx = w_rx_tick ? r_div : r_rx_cnt - 16'd1;
    case (r_rx_state)
      S_IDLE: begin
        if (r_rx_s3 && !r_rx_s2) begin
          w_rx_cnt_nx   = w_half_load;
          w_rx_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_rx_tick) begin
          w_rx_bit_nx   = 3'd0;
          w_rx_state_nx = r_rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_rx_tick) begin
          w_rx_shift_nx = {r_rx_s2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_nx = S_STOP;
          else                  w_rx_bit_nx   = r_rx_bit + 3'd1;
        end
      end
      S_STOP: begin
        // After a bad stop bit, hold here until the line returns high.
        if (r_rx_wait) begin
          if (r_rx_s2) begin
            w_rx_wait_nx  = 1'b0;
            w_rx_state_nx = S_IDLE;
          end
        end else if (w_rx_tick) begin
          if (r_rx_s2) begin
            w_rx_push     = 1'b1;
            w_rx_state_nx = S_IDLE;
          end else begin
            w_rx_ferr    = 1'b1;
            w_rx_wait_nx = 1'b1;
          end
        end
      end
      default: w_rx_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_wait  <= 1'b0;
    end else begin
      r_rx_s1    <= uart_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      r_rx_wait  <= w_rx_wait_nx;
    end
  end

  always_ff @(posedge clk) begin
    r_rx_shift <= w_rx_shift_nx;
  end

  uart_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_din   (r_rx_shift),
    .i_pop   (w_rd_data),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_overflow = w_rx_push && w_fifo_full && !w_rd_data;

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div       <= RESET_DIV;
      r_int_en    <= 2'b00;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr_stat) begin
        r_int_en <= reg_data_in[ST_INT_EN_HI:ST_INT_EN_LO];
        if (reg_data_in[ST_OVERRUN])   r_overrun   <= 1'b0;
        if (reg_data_in[ST_FRAME_ERR]) r_frame_err <= 1'b0;
      end
      if (w_overflow) r_overrun   <= 1'b1;
      if (w_rx_ferr)  r_frame_err <= 1'b1;
      if (w_wr_divl)  r_div[7:0]  <= reg_data_in;
      if (w_wr_divh)  r_div[15:8] <= reg_data_in;
    end
  end

  assign w_rx_avail = (w_fifo_count != '0);
  assign w_tx_ready = !r_hold_valid;
  assign w_tx_idle  = !r_hold_valid && (r_tx_state == S_IDLE);

  always_comb begin
    w_status                             = 8'h00;
    w_status[ST_RX_AVAIL]                = w_rx_avail;
    w_status[ST_TX_READY]                = w_tx_ready;
    w_status[ST_TX_IDLE]                 = w_tx_idle;
    w_status[ST_OVERRUN]                 = r_overrun;
    w_status[ST_FRAME_ERR]               = r_frame_err;
    w_status[ST_INT_EN_HI:ST_INT_EN_LO]  = r_int_en;
  end

  always_comb begin
    reg_data_out = 8'h00;
    case (reg_addr)
      UART_DATA: reg_data_out = w_fifo_empty ? 8'h00 : w_fifo_dout;
      UART_STAT: reg_data_out = w_status;
      UART_DIVL: reg_data_out = r_div[7:0];
      UART_DIVH: reg_data_out = r_div[15:8];
      default:   reg_data_out = 8'h00;
    endcase
  end

  assign interrupt = (w_rx_avail & r_int_en[0]) | (w_tx_ready & r_int_en[1]) |
                     r_overrun | r_frame_err;

endmodule
